// File: rtl/dac_pkg.sv
// dac_pkg: shared definitions for the MCP4921-class DAC SPI driver.
//   state_t     - driver FSM states
//   *_BIT       - bit positions inside the 16-bit DAC command frame
//   build_frame - assembles a command frame from the config bits and a sample
package dac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT,
    CAPTURE,
    SHIFT,
    CS_HOLD,
    CS_GAP,
    LDAC
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int CHAN_BIT   = 15;
  localparam int BUF_BIT    = 14;
  localparam int GA_N_BIT   = 13;
  localparam int SHDN_N_BIT = 12;
  localparam int DATA_MSB   = 11;
  localparam int DATA_LSB   = 0;

  // Channel A is always used and the DAC is never shut down, so those bits
  // are fixed; only buffer/gain come from configuration.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                   vref_buf,
    input logic                   gain_1x,
    input logic [DATA_MSB:DATA_LSB] sample
  );
    logic [FRAME_BITS-1:0] f;
    f                     = '0;
    f[CHAN_BIT]           = 1'b0;
    f[BUF_BIT]            = vref_buf;
    f[GA_N_BIT]           = gain_1x;
    f[SHDN_N_BIT]         = 1'b1;
    f[DATA_MSB:DATA_LSB]  = sample;
    return f;
  endfunction

endpackage

// File: rtl/sample_rate_divider.sv
// sample_rate_divider: free-running counter that marks the audio sample rate.
//   i_clock   - system clock
//   i_reset_n - synchronous active-low reset (counter returns to 0)
//   o_tick    - high for the one cycle in which the counter equals SAMPLE_DIV-1
module sample_rate_divider #(
  parameter int SAMPLE_DIV = 1024
) (
  input  logic i_clock,
  input  logic i_reset_n,
  output logic o_tick
);

  localparam int             CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_tick = (count == LAST);

endmodule

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: paces the mixer at the audio sample rate, captures its
// 12-bit result and shifts it to an MCP4921-class DAC, then pulses LDAC.
//   i_clock       - system clock
//   i_reset_n     - synchronous active-low reset; aborts any frame in flight
//   i_enable      - gates sample ticks (a frame already started completes)
//   i_sample      - mixer output, sampled only in CAPTURE
//   o_mix_execute - one-clock strobe to the mixer
//   o_dac_cs_n    - DAC chip select (active low)
//   o_dac_sck     - SPI clock, mode 0
//   o_dac_sdi     - SPI data, MSB first
//   o_dac_ldac_n  - DAC latch strobe (active low)
//   o_busy        - high from execute strobe until back in IDLE
//   o_overrun     - one-clock pulse when an enabled tick is dropped
module dac_spi_driver
  import dac_pkg::*;
#(
  parameter int   CLK_DIV     = 2,
  parameter int   SAMPLE_DIV  = 1024,
  parameter logic DAC_BUF     = 1'b0,
  parameter logic DAC_GAIN_1X = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic [11:0] i_sample,
  output logic        o_mix_execute,
  output logic        o_dac_cs_n,
  output logic        o_dac_sck,
  output logic        o_dac_sdi,
  output logic        o_dac_ldac_n,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int            HW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

  logic                  tick;
  state_t                state_q, state_d;
  logic [HW-1:0]         half_q, half_d;
  logic                  phase_q, phase_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  half_last;
  logic                  exec_d, cs_d, sck_d, sdi_d, ldac_d, busy_d, ovr_d;

  sample_rate_divider #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_divider (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .o_tick   (tick)
  );

  assign half_last = (half_q == HALF_LAST);

  // Next state plus next output values. Outputs are derived from the state
  // being entered so that the registered outputs line up with the state.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    frame_d = frame_q;

    case (state_q)
      IDLE: begin
        if (tick && i_enable) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = WAIT;
      // Mixer result becomes valid after EXEC; sampling one cycle later.
      WAIT:    state_d = CAPTURE;
      CAPTURE: begin
        frame_d = build_frame(DAC_BUF, DAC_GAIN_1X, i_sample);
        state_d = SHIFT;
        half_d  = '0;
        phase_d = 1'b0;
        bit_d   = 4'd15;
      end
      // phase 0 = SCK low half, phase 1 = SCK high half of the current bit.
      SHIFT: begin
        if (half_last) begin
          half_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else if (bit_q == 4'd0) begin
            phase_d = 1'b0;
            state_d = CS_HOLD;
          end else begin
            phase_d = 1'b0;
            bit_d   = bit_q - 4'd1;
          end
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      CS_HOLD: begin
        if (half_last) begin
          half_d  = '0;
          state_d = CS_GAP;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      CS_GAP: begin
        if (half_last) begin
          half_d  = '0;
          state_d = LDAC;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      LDAC: begin
        if (half_last) begin
          half_d  = '0;
          state_d = IDLE;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    exec_d = (state_d == EXEC);
    cs_d   = !((state_d == SHIFT) || (state_d == CS_HOLD));
    sck_d  = (state_d == SHIFT) && phase_d;
    ldac_d = (state_d != LDAC);
    busy_d = (state_d != IDLE);

    // SDI changes only when a new bit starts (SCK falling); it holds its
    // last value through the tail of the frame and clears in IDLE.
    sdi_d = o_dac_sdi;
    if (state_d == IDLE) begin
      sdi_d = 1'b0;
    end else if (state_d == SHIFT) begin
      sdi_d = frame_d[bit_d];
    end

    ovr_d = tick && i_enable && (state_q != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      half_q        <= '0;
      phase_q       <= 1'b0;
      bit_q         <= 4'd0;
      frame_q       <= '0;
      o_mix_execute <= 1'b0;
      o_dac_cs_n    <= 1'b1;
      o_dac_sck     <= 1'b0;
      o_dac_sdi     <= 1'b0;
      o_dac_ldac_n  <= 1'b1;
      o_busy        <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      state_q       <= state_d;
      half_q        <= half_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      frame_q       <= frame_d;
      o_mix_execute <= exec_d;
      o_dac_cs_n    <= cs_d;
      o_dac_sck     <= sck_d;
      o_dac_sdi     <= sdi_d;
      o_dac_ldac_n  <= ldac_d;
      o_busy        <= busy_d;
      o_overrun     <= ovr_d;
    end
  end

endmodule
